// File: rtl/afe_ctrl_regs_s_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_if : AXI4-Lite bundle (aw/w/b/ar/r channels, no prot/user).
//   modport s : responder view (used by afe_ctrl_regs_s)
//   modport m : initiator view
// ---------------------------------------------------------------------------
interface axi4_lite_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport s (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport m (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/afe_ctrl_regs_s.sv
// ---------------------------------------------------------------------------
// afe_ctrl_regs_s : AXI4-Lite responder for the AFE system control/status
// register window.
//   clk, rst_n      : clock, asynchronous active-low reset
//   afe_ctrl_i      : AXI4-Lite responder port
//   afe_ready, link_ok, dc_coarse_done, sync_done : async AFE status inputs
//   afe_rst, afe_ena: CTRL[0], CTRL[1]
//   ctrl_wr_p       : one-cycle pulse on every accepted CTRL write
// Map: 0x0 CTRL (RW, bits[1:0]), 0x4 STATUS (RO), 0x8 SCRATCH (RW), 0xC ID (RO)
// ---------------------------------------------------------------------------
module afe_ctrl_regs_s #(
   parameter int unsigned   AW       = 32,
   parameter int unsigned   DW       = 32,
   parameter logic [AW-1:0] BASE     = 32'h4300_0000,
   parameter logic [31:0]   ID_VAL   = 32'hAFE0_0001,
   parameter logic [31:0]   CTRL_RST = 32'h0000_0001
) (
   input  logic   clk,
   input  logic   rst_n,
   axi4_lite_if.s afe_ctrl_i,
   input  logic   afe_ready,
   input  logic   link_ok,
   input  logic   dc_coarse_done,
   input  logic   sync_done,
   output logic   afe_rst,
   output logic   afe_ena,
   output logic   ctrl_wr_p
);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;   // have AW, waiting for W
   localparam logic [1:0] W_ADDR = 2'd2;   // have W, waiting for AW
   localparam logic [1:0] W_RESP = 2'd3;

   localparam logic R_IDLE = 1'b0;
   localparam logic R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write path state
   logic [1:0]      w_state_q, w_state_d;
   logic            awready_q, awready_d;
   logic            wready_q,  wready_d;
   logic [AW-1:2]   awaddr_q,  awaddr_d;
   logic [DW-1:0]   wdata_q,   wdata_d;
   logic [DW/8-1:0] wstrb_q,   wstrb_d;
   logic            bvalid_q,  bvalid_d;
   logic [1:0]      bresp_q,   bresp_d;
   logic            ctrl_wr_p_q, ctrl_wr_p_d;

   // Read path state
   logic            r_state_q, r_state_d;
   logic            arready_q, arready_d;
   logic            rvalid_q,  rvalid_d;
   logic [1:0]      rresp_q,   rresp_d;
   logic [DW-1:0]   rdata_q,   rdata_d;

   // Register file and status synchronizers
   logic [1:0]      ctrl_q,    ctrl_d;
   logic [DW-1:0]   scratch_q, scratch_d;
   logic [3:0]      status_meta_q, status_meta_d;
   logic [3:0]      status_sync_q, status_sync_d;

   // Write-side decode helpers
   logic            aw_hs, w_hs, wr_commit, wr_in_win;
   logic [AW-1:2]   wr_word;
   logic [1:0]      wr_off;
   logic [DW-1:0]   wr_data;
   logic [DW/8-1:0] wr_strb;

   // Read-side decode helpers
   logic            ar_hs, rd_in_win;
   logic [AW-1:2]   rd_word;

   // NOTE: every _d below is computed in always_comb with a default assigned
   // first, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      status_meta_d = {sync_done, dc_coarse_done, link_ok, afe_ready};
      status_sync_d = status_meta_q;

      aw_hs = afe_ctrl_i.awvalid & awready_q;
      w_hs  = afe_ctrl_i.wvalid  & wready_q;

      // The last handshake of a write may be this very cycle, so decode from
      // the live bus for whichever half arrives now, else from the capture.
      wr_word   = aw_hs ? afe_ctrl_i.awaddr[AW-1:2] : awaddr_q;
      wr_data   = w_hs  ? afe_ctrl_i.wdata : wdata_q;
      wr_strb   = w_hs  ? afe_ctrl_i.wstrb : wstrb_q;
      wr_in_win = (wr_word[AW-1:4] == BASE[AW-1:4]);
      wr_off    = wr_word[3:2];

      w_state_d   = w_state_q;
      awaddr_d    = aw_hs ? afe_ctrl_i.awaddr[AW-1:2] : awaddr_q;
      wdata_d     = wr_data;
      wstrb_d     = wr_strb;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;
      ctrl_d      = ctrl_q;
      scratch_d   = scratch_q;
      ctrl_wr_p_d = 1'b0;
      wr_commit   = 1'b0;

      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) wr_commit = 1'b1;
            else if (aw_hs)    w_state_d = W_DATA;
            else if (w_hs)     w_state_d = W_ADDR;
         end
         W_DATA: if (w_hs)  wr_commit = 1'b1;
         W_ADDR: if (aw_hs) wr_commit = 1'b1;
         default: begin
            if (afe_ctrl_i.bready) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
            end
         end
      endcase

      if (wr_commit) begin
         w_state_d = W_RESP;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_SLVERR;
         if (wr_in_win && wr_off == 2'd0) begin
            bresp_d     = RESP_OKAY;
            ctrl_wr_p_d = 1'b1;   // pulses even when no strobe is set
            if (wr_strb[0]) ctrl_d = wr_data[1:0];
         end else if (wr_in_win && wr_off == 2'd2) begin
            bresp_d = RESP_OKAY;
            for (int b = 0; b < DW/8; b++)
               if (wr_strb[b]) scratch_d[b*8 +: 8] = wr_data[b*8 +: 8];
         end
      end

      // Ready flags are registered from the next state so they are low in
      // reset and never open while a response is still pending.
      awready_d = (w_state_d == W_IDLE) || (w_state_d == W_ADDR);
      wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_DATA);

      ar_hs     = afe_ctrl_i.arvalid & arready_q;
      rd_word   = afe_ctrl_i.araddr[AW-1:2];
      rd_in_win = (rd_word[AW-1:4] == BASE[AW-1:4]);

      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;

      if (r_state_q == R_IDLE) begin
         if (ar_hs) begin
            r_state_d = R_DATA;
            rvalid_d  = 1'b1;
            rresp_d   = RESP_OKAY;
            // Register values are the pre-edge ones, so a same-cycle write
            // to the same register is not visible to this read.
            if (!rd_in_win) begin
               rresp_d = RESP_SLVERR;
               rdata_d = '0;
            end else begin
               case (rd_word[3:2])
                  2'd0:    rdata_d = {{(DW-2){1'b0}}, ctrl_q};
                  2'd1:    rdata_d = {{(DW-4){1'b0}}, status_sync_q};
                  2'd2:    rdata_d = scratch_q;
                  default: rdata_d = ID_VAL[DW-1:0];
               endcase
            end
         end
      end else if (afe_ctrl_i.rready) begin
         r_state_d = R_IDLE;
         rvalid_d  = 1'b0;
      end

      arready_d = (r_state_d == R_IDLE);
   end

   // NOTE: state is updated with non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q     <= W_IDLE;
         awready_q     <= 1'b0;
         wready_q      <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         bvalid_q      <= 1'b0;
         bresp_q       <= RESP_OKAY;
         ctrl_wr_p_q   <= 1'b0;
         r_state_q     <= R_IDLE;
         arready_q     <= 1'b0;
         rvalid_q      <= 1'b0;
         rresp_q       <= RESP_OKAY;
         rdata_q       <= '0;
         ctrl_q        <= CTRL_RST[1:0];
         scratch_q     <= '0;
         status_meta_q <= '0;
         status_sync_q <= '0;
      end else begin
         w_state_q     <= w_state_d;
         awready_q     <= awready_d;
         wready_q      <= wready_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         bvalid_q      <= bvalid_d;
         bresp_q       <= bresp_d;
         ctrl_wr_p_q   <= ctrl_wr_p_d;
         r_state_q     <= r_state_d;
         arready_q     <= arready_d;
         rvalid_q      <= rvalid_d;
         rresp_q       <= rresp_d;
         rdata_q       <= rdata_d;
         ctrl_q        <= ctrl_d;
         scratch_q     <= scratch_d;
         status_meta_q <= status_meta_d;
         status_sync_q <= status_sync_d;
      end
   end

   assign afe_ctrl_i.awready = awready_q;
   assign afe_ctrl_i.wready  = wready_q;
   assign afe_ctrl_i.bvalid  = bvalid_q;
   assign afe_ctrl_i.bresp   = bresp_q;
   assign afe_ctrl_i.arready = arready_q;
   assign afe_ctrl_i.rvalid  = rvalid_q;
   assign afe_ctrl_i.rresp   = rresp_q;
   assign afe_ctrl_i.rdata   = rdata_q;

   assign afe_rst   = ctrl_q[0];
   assign afe_ena   = ctrl_q[1];
   assign ctrl_wr_p = ctrl_wr_p_q;

endmodule

// File: tb/tb_afe_ctrl_regs_s.sv
// ---------------------------------------------------------------------------
// tb_afe_ctrl_regs_s : directed self-checking bench for afe_ctrl_regs_s.
// ---------------------------------------------------------------------------
module tb_afe_ctrl_regs_s;

   localparam logic [31:0] BASE = 32'h4300_0000;

   logic clk;
   logic rst_n;
   logic afe_ready, link_ok, dc_coarse_done, sync_done;
   logic afe_rst, afe_ena, ctrl_wr_p;

   int errors = 0;
   int checks = 0;

   axi4_lite_if #(.AW(32), .DW(32)) bus ();

   afe_ctrl_regs_s #(.BASE(BASE)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .afe_ctrl_i     (bus),
      .afe_ready      (afe_ready),
      .link_ok        (link_ok),
      .dc_coarse_done (dc_coarse_done),
      .sync_done      (sync_done),
      .afe_rst        (afe_rst),
      .afe_ena        (afe_ena),
      .ctrl_wr_p      (ctrl_wr_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic pulse);
      logic aw_done, w_done, aw_now, w_now, got_b;
      bus.awaddr = addr; bus.awvalid = 1'b1;
      bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
      bus.bready = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; got_b = 1'b0;
      resp = 2'bxx; pulse = 1'bx;
      for (int i = 0; i < 16 && !(aw_done && w_done); i++) begin
         aw_now = bus.awvalid & bus.awready;
         w_now  = bus.wvalid & bus.wready;
         tick();
         if (aw_now) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
         if (w_now)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      for (int i = 0; i < 16 && !got_b; i++) begin
         if (bus.bvalid) begin
            got_b = 1'b1; resp = bus.bresp; pulse = ctrl_wr_p;
         end else tick();
      end
      if (!got_b) begin
         checks++; errors++;
         $display("FAIL write_timeout addr=%h: no bvalid within budget", addr);
      end
      tick();
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      logic fired, fire, got_r;
      bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
      fired = 1'b0; got_r = 1'b0;
      data = 'x; resp = 2'bxx;
      for (int i = 0; i < 16 && !fired; i++) begin
         fire = bus.arready;
         tick();
         if (fire) fired = 1'b1;
      end
      bus.arvalid = 1'b0;
      for (int i = 0; i < 16 && !got_r; i++) begin
         if (bus.rvalid) begin
            got_r = 1'b1; data = bus.rdata; resp = bus.rresp;
         end else tick();
      end
      if (!got_r) begin
         checks++; errors++;
         $display("FAIL read_timeout addr=%h: no rvalid within budget", addr);
      end
      tick();
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r;
      rst_n = 1'b0;
      tick(); tick();
      checks++;
      if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
           afe_rst, afe_ena, ctrl_wr_p} !== 8'b0000_0100) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=00000100",
                  {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                   afe_rst, afe_ena, ctrl_wr_p});
      end
      checks++;
      if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
         errors++;
         $display("FAIL reset_resp_data got=%h exp=0", {bus.bresp, bus.rresp, bus.rdata});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
         errors++;
         $display("FAIL ready_after_reset got=%b exp=111", {bus.awready, bus.wready, bus.arready});
      end
      axi_read(BASE + 32'h0, d, r);
      checks++;
      if ({r, d} !== {2'b00, 32'h0000_0001}) begin
         errors++; $display("FAIL reset_ctrl got=%h/%b exp=00000001/00", d, r);
      end
      axi_read(BASE + 32'h8, d, r);
      checks++;
      if ({r, d} !== {2'b00, 32'h0}) begin
         errors++; $display("FAIL reset_scratch got=%h/%b exp=00000000/00", d, r);
      end
      axi_read(BASE + 32'hC, d, r);
      checks++;
      if ({r, d} !== {2'b00, 32'hAFE0_0001}) begin
         errors++; $display("FAIL id_read got=%h/%b exp=afe00001/00", d, r);
      end
   endtask

   task automatic test_ctrl_same_cycle();
      bus.awaddr = BASE; bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.bready = 1'b1;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      checks++;
      if ({bus.bvalid, bus.bresp, afe_rst, ctrl_wr_p, bus.awready, bus.wready} !== 7'b1_00_0_1_00) begin
         errors++;
         $display("FAIL ctrl_write_resp got=%b exp=1000100",
                  {bus.bvalid, bus.bresp, afe_rst, ctrl_wr_p, bus.awready, bus.wready});
      end
      tick();
      checks++;
      if ({bus.bvalid, ctrl_wr_p, bus.awready} !== 3'b001) begin
         errors++;
         $display("FAIL ctrl_write_done got=%b exp=001", {bus.bvalid, ctrl_wr_p, bus.awready});
      end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d; logic [1:0] r;
      bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      checks++;
      if ({bus.awready, bus.wready, bus.bvalid} !== 3'b100) begin
         errors++;
         $display("FAIL w_first_wait got=%b exp=100", {bus.awready, bus.wready, bus.bvalid});
      end
      tick(); tick();
      bus.awaddr = BASE + 32'h8; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      checks++;
      if ({bus.bvalid, bus.bresp, ctrl_wr_p} !== 4'b1_00_0) begin
         errors++;
         $display("FAIL w_first_resp got=%b exp=1000", {bus.bvalid, bus.bresp, ctrl_wr_p});
      end
      tick();
      axi_read(BASE + 32'h8, d, r);
      checks++;
      if ({r, d} !== {2'b00, 32'h00AD_00EF}) begin
         errors++; $display("FAIL scratch_strobe got=%h/%b exp=00ad00ef/00", d, r);
      end
   endtask

   task automatic test_slverr();
      logic [31:0] d; logic [1:0] r; logic p;
      axi_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, r, p);
      checks++;
      if ({r, p} !== 3'b10_0) begin errors++; $display("FAIL wr_status_err got=%b exp=100", {r, p}); end
      axi_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, r, p);
      checks++;
      if ({r, p} !== 3'b10_0) begin errors++; $display("FAIL wr_id_err got=%b exp=100", {r, p}); end
      axi_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, r, p);
      checks++;
      if ({r, p} !== 3'b10_0) begin errors++; $display("FAIL wr_oow_err got=%b exp=100", {r, p}); end
      axi_read(BASE + 32'h10, d, r);
      checks++;
      if ({r, d} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL rd_oow_err got=%h/%b exp=00000000/10", d, r);
      end
      axi_read(BASE + 32'h0, d, r);
      checks++;
      if ({r, d, afe_rst, afe_ena} !== {2'b00, 32'h0, 2'b00}) begin
         errors++; $display("FAIL ctrl_unchanged got=%h/%b exp=00000000/00", d, r);
      end
      axi_read(BASE + 32'h8, d, r);
      checks++;
      if (d !== 32'h00AD_00EF) begin errors++; $display("FAIL scratch_unchanged got=%h exp=00ad00ef", d); end
      axi_read(BASE + 32'hC, d, r);
      checks++;
      if (d !== 32'hAFE0_0001) begin errors++; $display("FAIL id_unchanged got=%h exp=afe00001", d); end
   endtask

   task automatic test_status();
      logic [31:0] d; logic [1:0] r;
      afe_ready = 1'b1; link_ok = 1'b1;
      tick(); tick(); tick();
      bus.araddr = BASE + 32'h4; bus.arvalid = 1'b1; bus.rready = 1'b0;
      tick();
      bus.arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) sync_done = 1'b1;
         checks++;
         if ({bus.rvalid, bus.arready, bus.rresp, bus.rdata} !== {1'b1, 1'b0, 2'b00, 32'h3}) begin
            errors++;
            $display("FAIL status_hold[%0d] got rvalid=%b arready=%b rdata=%h exp 1/0/00000003",
                     i, bus.rvalid, bus.arready, bus.rdata);
         end
         tick();
      end
      bus.rready = 1'b1;
      tick();
      checks++;
      if ({bus.rvalid, bus.arready} !== 2'b01) begin
         errors++; $display("FAIL status_release got=%b exp=01", {bus.rvalid, bus.arready});
      end
      dc_coarse_done = 1'b1;
      tick(); tick(); tick();
      axi_read(BASE + 32'h4, d, r);
      checks++;
      if ({r, d} !== {2'b00, 32'hF}) begin errors++; $display("FAIL status_all got=%h/%b exp=0000000f/00", d, r); end
   endtask

   task automatic test_same_cycle_rw();
      logic [31:0] d; logic [1:0] r;
      bus.awaddr = BASE + 32'h8; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
      bus.araddr = BASE + 32'h8; bus.bready = 1'b1; bus.rready = 1'b1;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      checks++;
      if ({bus.bvalid, bus.rvalid, bus.rdata} !== {2'b11, 32'h00AD_00EF}) begin
         errors++;
         $display("FAIL rw_old_value got b=%b r=%b rdata=%h exp 1/1/00ad00ef",
                  bus.bvalid, bus.rvalid, bus.rdata);
      end
      tick();
      axi_read(BASE + 32'h8, d, r);
      checks++;
      if (d !== 32'h1234_5678) begin errors++; $display("FAIL rw_new_value got=%h exp=12345678", d); end
   endtask

   task automatic test_ctrl_strobes();
      logic [31:0] d; logic [1:0] r; logic p;
      axi_write(BASE, 32'h3, 4'h0, r, p);
      checks++;
      if ({r, p} !== 3'b00_1) begin errors++; $display("FAIL zero_strb_pulse got=%b exp=001", {r, p}); end
      axi_read(BASE, d, r);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL zero_strb_ctrl got=%h exp=00000000", d); end
      axi_write(BASE, 32'hFFFF_FFFE, 4'h1, r, p);
      axi_read(BASE, d, r);
      checks++;
      if ({d, afe_ena, afe_rst} !== {32'h2, 2'b10}) begin
         errors++; $display("FAIL ctrl_ena got=%h ena=%b rst=%b exp=00000002/1/0", d, afe_ena, afe_rst);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r; logic p;
      bus.bready = 1'b0;
      bus.awaddr = BASE; bus.wdata = 32'h3; bus.wstrb = 4'h1;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      tick(); tick();
      checks++;
      if ({bus.bvalid, bus.awready, afe_rst, afe_ena} !== 4'b1011) begin
         errors++;
         $display("FAIL bvalid_held got=%b exp=1011", {bus.bvalid, bus.awready, afe_rst, afe_ena});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.bvalid, afe_rst, afe_ena} !== 3'b010) begin
         errors++; $display("FAIL mid_reset got=%b exp=010", {bus.bvalid, afe_rst, afe_ena});
      end
      bus.bready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      axi_read(BASE + 32'h8, d, r);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL scratch_after_reset got=%h exp=00000000", d); end
      axi_write(BASE, 32'h2, 4'hF, r, p);
      checks++;
      if ({r, p, afe_ena, afe_rst} !== 5'b00_1_1_0) begin
         errors++; $display("FAIL write_after_reset got=%b exp=00110", {r, p, afe_ena, afe_rst});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      afe_ready = 1'b0; link_ok = 1'b0; dc_coarse_done = 1'b0; sync_done = 1'b0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      test_reset();
      test_ctrl_same_cycle();
      test_w_before_aw();
      test_slverr();
      test_status();
      test_same_cycle_rw();
      test_ctrl_strobes();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/afe_ctrl_regs_s.md
Name: afe_ctrl_regs_s

Overview:
AXI4-Lite responder (slave) holding the AFE system control/status register window at AFE_SYS_BASE; it is the target of the initiators that write CTRL_REG during LLRF init. It decodes single-beat writes/reads, drives AFE control bits, samples AFE status, and emits a one-cycle pulse on every CTRL_REG write.

Parameters:
AW, 32, AXI address width
DW, 32, AXI data width (fixed 32; other values unsupported)
BASE, AFE_SYS_BASE, window base address; decode uses addr[3:2] when addr[AW-1:4] == BASE[AW-1:4]
ID_VAL, 32'hAFE0_0001, value returned by read-only ID register
CTRL_RST, 32'h0000_0001, reset value of CTRL register (bit0 = afe_rst asserted)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
afe_ctrl_i  axi4_lite_if.s  -  AXI4-Lite responder port (aw/w/b/ar/r channels)
afe_ready  in  1  AFE status, sampled into STATUS[0]
link_ok  in  1  STATUS[1]
dc_coarse_done  in  1  STATUS[2]
sync_done  in  1  STATUS[3]
afe_rst  out  1  CTRL[0]
afe_ena  out  1  CTRL[1]
ctrl_wr_p  out  1  one-clk pulse when CTRL is written (any strobe)

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset rst_n. While rst_n=0: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, CTRL=CTRL_RST, SCRATCH=0, ctrl_wr_p=0, status sync flops=0. Deassertion takes effect on next clk edge.
- Register map (offset): 0x0 CTRL RW (bits[1:0] used, others read 0); 0x4 STATUS RO {28'b0, sync_done, dc_coarse_done, link_ok, afe_ready}; 0x8 SCRATCH RW 32b; 0xC ID RO = ID_VAL.
- Status inputs pass through 2-flop synchronizers; STATUS reflects inputs 2 clk late.
- Write FSM: wIDLE -> wDATA (have AW, need W) / wADDR (have W, need AW) -> wRESP -> wIDLE.
  - awready=1 only in wIDLE/wADDR, wready=1 only in wIDLE/wDATA; AW and W accepted in any order or same cycle (same cycle goes straight to wRESP).
  - Captured addr/data/strb held; register update happens on the cycle entering wRESP; bvalid asserts that same edge (write latency 1 clk after last of AW/W handshake).
  - wstrb honoured per byte; CTRL/SCRATCH only bytes with strobe set change.
  - bresp=OKAY(00) for CTRL/SCRATCH; SLVERR(10) for STATUS, ID, or out-of-window address (no state change).
  - bvalid held until bready; wRESP -> wIDLE on bvalid&bready. No new AW/W accepted while bvalid=1 (single outstanding).
  - ctrl_wr_p=1 for exactly the cycle bvalid rises for an OKAY write to CTRL, even if all strobes 0.
- Read FSM: rIDLE (arready=1) -> rDATA on arvalid; rdata/rresp registered on same edge; rvalid held until rready; rDATA -> rIDLE on handshake. rresp=SLVERR, rdata=0 for out-of-window address. Read latency 1 clk.
- Read and write paths independent; same-cycle read and write to same register: read returns old value.
- bready/rready low indefinitely: outputs stable, no further acceptance on that channel.
- rst_n low mid-transaction: transaction discarded, bvalid/rvalid drop immediately, registers to reset values.

Test Plan:
- Reset: rst_n=0 -> CTRL reads 0x1, afe_rst=1, afe_ena=0, SCRATCH=0, ID reads 0xAFE00001 with rresp=00.
- Write CTRL=0x0 with AW and W same cycle, bready=1 -> bvalid 1 clk later, bresp=00, afe_rst=0, ctrl_wr_p single-cycle pulse.
- W issued 3 clk before AW to SCRATCH, data 0xDEADBEEF, wstrb=0b0101 -> SCRATCH=0x00AD00EF, readback matches.
- Write STATUS and address BASE+0x10 -> bresp=10, register contents unchanged, ctrl_wr_p=0; read BASE+0x10 -> rresp=10, rdata=0.
- Set afe_ready=1, link_ok=1 -> STATUS read 3 clk later = 0x3; hold rready=0 for 5 clk -> rvalid/rdata stable, arready=0.
- Pull rst_n low while bvalid=1 awaiting bready -> bvalid=0 immediately, CTRL=0x1; after release, next write completes normally.
